// File: rtl/instr_decoder_pkg.sv
// Shared widths, write-enable bit indices and opp/addr_mode encodings for the 6502 opcode decoder.
// Used by instr_decoder, opcode_lut and instr_decoder_if.
package instr_decoder_pkg;

    localparam int unsigned ADDR_WIDTH = 16;
    localparam int unsigned REG_WIDTH  = 8;
    localparam int unsigned WE_WIDTH   = 7;

    localparam int unsigned WE_PC   = 0;
    localparam int unsigned WE_SP   = 1;
    localparam int unsigned WE_ADD  = 2;
    localparam int unsigned WE_X    = 3;
    localparam int unsigned WE_Y    = 4;
    localparam int unsigned WE_STAT = 5;
    localparam int unsigned WE_DOUT = 6;

    typedef logic [3:0] opp_t;
    typedef logic [3:0] am_t;

    // ORA..SBC are contiguous so the cc=01 group maps as OPP_ORA + aaa.
    localparam opp_t OPP_NOP = 4'd0;
    localparam opp_t OPP_ORA = 4'd1;
    localparam opp_t OPP_AND = 4'd2;
    localparam opp_t OPP_EOR = 4'd3;
    localparam opp_t OPP_ADC = 4'd4;
    localparam opp_t OPP_STA = 4'd5;
    localparam opp_t OPP_LDA = 4'd6;
    localparam opp_t OPP_CMP = 4'd7;
    localparam opp_t OPP_SBC = 4'd8;
    localparam opp_t OPP_STX = 4'd9;
    localparam opp_t OPP_LDX = 4'd10;
    localparam opp_t OPP_STY = 4'd11;
    localparam opp_t OPP_LDY = 4'd12;

    localparam am_t AM_IMPL = 4'd0;
    localparam am_t AM_IMM  = 4'd1;
    localparam am_t AM_ZP   = 4'd2;
    localparam am_t AM_ZPX  = 4'd3;
    localparam am_t AM_ZPY  = 4'd4;
    localparam am_t AM_ABS  = 4'd5;
    localparam am_t AM_ABSX = 4'd6;
    localparam am_t AM_ABSY = 4'd7;
    localparam am_t AM_INDX = 4'd8;
    localparam am_t AM_INDY = 4'd9;

    typedef struct packed {
        opp_t                opp;
        am_t                 addr_mode;
        logic [1:0]          operand_bytes;
        logic [WE_WIDTH-1:0] we_mask;
        logic                illegal;
    } decode_t;

    function automatic logic [1:0] mode_bytes(am_t mode);
        return (mode == AM_ABS || mode == AM_ABSX || mode == AM_ABSY) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Fetcher-side and register-file-side signals of the opcode decoder.
// master: fetcher / environment; slave: instr_decoder.
interface instr_decoder_if import instr_decoder_pkg::*; ();

    logic [ADDR_WIDTH-1:0] addr_in;
    logic [REG_WIDTH-1:0]  instruction_in;
    logic                  instruction_ready;
    opp_t                  opp;
    am_t                   addr_mode;
    logic [1:0]            operand_bytes;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  illegal;
    logic [WE_WIDTH-1:0]   we;
    logic                  instruction_done;

    modport master (
        output addr_in, instruction_in, instruction_ready,
        input  opp, addr_mode, operand_bytes, inst_addr, illegal, we, instruction_done
    );

    modport slave (
        input  addr_in, instruction_in, instruction_ready,
        output opp, addr_mode, operand_bytes, inst_addr, illegal, we, instruction_done
    );

endinterface

// File: rtl/opcode_lut.sv
// Combinational opcode -> {opp, addr_mode, operand_bytes, we_mask, illegal} lookup.
// DECODER_LOAD_FLAGS_EN: loads (LDA/LDX/LDY) also write STAT.
module opcode_lut
    import instr_decoder_pkg::*;
(
    input  logic [REG_WIDTH-1:0] opcode,
    output decode_t              dec
);

`ifdef DECODER_LOAD_FLAGS_EN
    localparam bit LoadFlags = 1'b1;
`else
    localparam bit LoadFlags = 1'b0;
`endif

    logic [2:0]          aaa, bbb;
    logic [1:0]          cc;
    logic                legal, is_load, idx_y;
    opp_t                opp;
    am_t                 mode;
    logic [WE_WIDTH-1:0] mask;

    assign aaa = opcode[7:5];
    assign bbb = opcode[4:2];
    assign cc  = opcode[1:0];

    always_comb begin
        legal   = 1'b0;
        is_load = aaa[0];
        idx_y   = cc[1];
        opp     = OPP_NOP;
        mode    = AM_IMPL;
        mask    = '0;
        case (cc)
            2'b01: begin
                legal = !(aaa == 3'b100 && bbb == 3'b010);
                opp   = OPP_ORA + opp_t'(aaa);
                case (bbb)
                    3'b000:  mode = AM_INDX;
                    3'b001:  mode = AM_ZP;
                    3'b010:  mode = AM_IMM;
                    3'b011:  mode = AM_ABS;
                    3'b100:  mode = AM_INDY;
                    3'b101:  mode = AM_ZPX;
                    3'b110:  mode = AM_ABSY;
                    default: mode = AM_ABSX;
                endcase
                case (aaa)
                    3'b100: mask[WE_DOUT] = 1'b1;
                    3'b101: begin
                        mask[WE_ADD]  = 1'b1;
                        mask[WE_STAT] = LoadFlags;
                    end
                    3'b110: mask[WE_STAT] = 1'b1;
                    default: begin
                        mask[WE_ADD]  = 1'b1;
                        mask[WE_STAT] = 1'b1;
                    end
                endcase
            end
            2'b00, 2'b10: begin
                if (aaa == 3'b100 || aaa == 3'b101) begin
                    legal = 1'b1;
                    // LDX/STX index with Y, LDY/STY index with X.
                    case (bbb)
                        3'b000:  begin mode = AM_IMM; legal = is_load; end
                        3'b001:  mode = AM_ZP;
                        3'b011:  mode = AM_ABS;
                        3'b101:  mode = idx_y ? AM_ZPY : AM_ZPX;
                        3'b111:  mode = idx_y ? AM_ABSY : AM_ABSX;
                        default: legal = 1'b0;
                    endcase
                    if (idx_y) opp = is_load ? OPP_LDX : OPP_STX;
                    else       opp = is_load ? OPP_LDY : OPP_STY;
                    if (!is_load) begin
                        mask[WE_DOUT] = 1'b1;
                    end else begin
                        mask[WE_X]    = idx_y;
                        mask[WE_Y]    = !idx_y;
                        mask[WE_STAT] = LoadFlags;
                    end
                end
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            dec = '{opp: opp, addr_mode: mode, operand_bytes: mode_bytes(mode),
                    we_mask: mask, illegal: 1'b0};
        end else begin
            dec = '{opp: OPP_NOP, addr_mode: AM_IMPL, operand_bytes: 2'd0,
                    we_mask: '0, illegal: 1'b1};
        end
    end

endmodule

// File: rtl/instr_decoder.sv
// 6502 opcode decoder: ready edge detect, opcode/address latch and IDLE->DECODE->EXECUTE->DONE FSM.
// Build option DECODER_LOAD_FLAGS_EN (see opcode_lut) adds STAT to load write-enables.
module instr_decoder
    import instr_decoder_pkg::*;
(
    input logic            clk,
    input logic            reset,
    instr_decoder_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StDecode, StExecute, StDone} state_e;

    state_e                state_q, state_d;
    logic                  ready_q;
    logic                  valid_q;
    logic [REG_WIDTH-1:0]  op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept;
    decode_t               dec;

    assign accept = bus.instruction_ready && !ready_q && (state_q == StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= bus.instruction_ready;
            if (accept) begin
                valid_q <= 1'b1;
                op_q    <= bus.instruction_in;
                addr_q  <= bus.addr_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (accept) state_d = StDecode;
            StDecode:  state_d = StExecute;
            StExecute: state_d = StDone;
            default:   state_d = StIdle;
        endcase
    end

    opcode_lut u_opcode_lut (
        .opcode (op_q),
        .dec    (dec)
    );

    // Decoded fields stay zero until the first accepted opcode after reset.
    always_comb begin
        bus.opp              = OPP_NOP;
        bus.addr_mode        = AM_IMPL;
        bus.operand_bytes    = 2'd0;
        bus.illegal          = 1'b0;
        bus.inst_addr        = '0;
        bus.we               = '0;
        bus.instruction_done = 1'b0;
        if (valid_q) begin
            bus.opp           = dec.opp;
            bus.addr_mode     = dec.addr_mode;
            bus.operand_bytes = dec.operand_bytes;
            bus.illegal       = dec.illegal;
            bus.inst_addr     = addr_q;
        end
        if (state_q == StExecute) bus.we = dec.we_mask;
        bus.instruction_done = (state_q == StDone);
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed spec vectors plus random opcodes against
// an expectation table built forward from the mnemonic/mode lists.
module tb_instr_decoder;
    import instr_decoder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    instr_decoder_if bus ();

    instr_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef DECODER_LOAD_FLAGS_EN
    localparam logic [6:0] LoadStat = 7'h20;
`else
    localparam logic [6:0] LoadStat = 7'h00;
`endif

    opp_t       exp_opp  [256];
    am_t        exp_mode [256];
    logic [1:0] exp_bytes[256];
    logic [6:0] exp_we   [256];
    logic       exp_ill  [256];

    function automatic logic [6:0] we_for(opp_t o);
        case (o)
            OPP_LDA:                   return 7'h04 | LoadStat;
            OPP_LDX:                   return 7'h08 | LoadStat;
            OPP_LDY:                   return 7'h10 | LoadStat;
            OPP_STA, OPP_STX, OPP_STY: return 7'h40;
            OPP_CMP:                   return 7'h20;
            default:                   return 7'h24;
        endcase
    endfunction

    function automatic logic [1:0] bytes_for(am_t m);
        return (m == AM_ABS || m == AM_ABSX || m == AM_ABSY) ? 2'd2 : 2'd1;
    endfunction

    task automatic set_entry(int code, opp_t o, am_t m);
        exp_opp[code]   = o;
        exp_mode[code]  = m;
        exp_bytes[code] = bytes_for(m);
        exp_we[code]    = we_for(o);
        exp_ill[code]   = 1'b0;
    endtask

    // Enumerate every supported (mnemonic, mode) pair and place it at aaa*32 + bbb*4 + cc.
    task automatic build_model();
        opp_t g1_ops[8]   = '{OPP_ORA, OPP_AND, OPP_EOR, OPP_ADC, OPP_STA, OPP_LDA, OPP_CMP, OPP_SBC};
        am_t  g1_modes[8] = '{AM_INDX, AM_ZP, AM_IMM, AM_ABS, AM_INDY, AM_ZPX, AM_ABSY, AM_ABSX};
        opp_t g2_ops[4]   = '{OPP_STY, OPP_LDY, OPP_STX, OPP_LDX};
        int   g2_bbb[5]   = '{0, 1, 3, 5, 7};
        for (int i = 0; i < 256; i++) begin
            exp_opp[i] = OPP_NOP; exp_mode[i] = AM_IMPL; exp_bytes[i] = 2'd0;
            exp_we[i] = 7'h00; exp_ill[i] = 1'b1;
        end
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                if (!(g1_ops[a] == OPP_STA && g1_modes[b] == AM_IMM))
                    set_entry(a * 32 + b * 4 + 1, g1_ops[a], g1_modes[b]);
        for (int k = 0; k < 4; k++) begin
            int  a     = 4 + (k % 2);
            int  c     = (k >= 2) ? 2 : 0;
            bit  uses_y = (c == 2);
            bit  load  = (a == 5);
            am_t modes[5];
            modes = '{AM_IMM, AM_ZP, AM_ABS, uses_y ? AM_ZPY : AM_ZPX,
                      uses_y ? AM_ABSY : AM_ABSX};
            for (int j = 0; j < 5; j++)
                if (load || j != 0)
                    set_entry(a * 32 + g2_bbb[j] * 4 + c, g2_ops[k], modes[j]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one opcode with a fresh ready edge; returns in the DECODE cycle with ready low.
    task automatic accept_op(logic [7:0] op, logic [15:0] addr);
        bus.instruction_in    = op;
        bus.addr_in           = addr;
        bus.instruction_ready = 1'b1;
        step();
        bus.instruction_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.instruction_ready = 1'b0;
        bus.instruction_in    = 8'h00;
        bus.addr_in           = 16'h0000;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.opp, bus.addr_mode, bus.operand_bytes, bus.inst_addr, bus.illegal,
                 bus.we, bus.instruction_done} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: opp=%0d mode=%0d bytes=%0d addr=%h ill=%b we=%h done=%b, all must be 0",
                         i, bus.opp, bus.addr_mode, bus.operand_bytes, bus.inst_addr, bus.illegal,
                         bus.we, bus.instruction_done);
            end
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] addr;
        opp_t        opp;
        am_t         mode;
        logic [1:0]  bytes;
        logic [6:0]  we;
    } vec_t;

    task automatic test_directed();
        vec_t v[4] = '{
            '{8'hA9, 16'h0010, OPP_LDA, AM_IMM, 2'd1, 7'h04 | LoadStat},
            '{8'h85, 16'h1234, OPP_STA, AM_ZP,  2'd1, 7'h40},
            '{8'h6D, 16'hBEEF, OPP_ADC, AM_ABS, 2'd2, 7'h24},
            '{8'hAE, 16'hFFFE, OPP_LDX, AM_ABS, 2'd2, 7'h08 | LoadStat}
        };
        for (int i = 0; i < 4; i++) begin
            accept_op(v[i].op, v[i].addr);
            checks++;
            if (bus.opp !== v[i].opp || bus.addr_mode !== v[i].mode ||
                bus.operand_bytes !== v[i].bytes || bus.inst_addr !== v[i].addr ||
                bus.illegal !== 1'b0 || bus.we !== 7'h00) begin
                failures++;
                $display("FAIL directed_decode op=%h: opp=%0d mode=%0d bytes=%0d addr=%h ill=%b we=%h, need opp=%0d mode=%0d bytes=%0d addr=%h ill=0 we=00",
                         v[i].op, bus.opp, bus.addr_mode, bus.operand_bytes, bus.inst_addr,
                         bus.illegal, bus.we, v[i].opp, v[i].mode, v[i].bytes, v[i].addr);
            end
            step();
            checks++;
            if (bus.we !== v[i].we || bus.instruction_done !== 1'b0) begin
                failures++;
                $display("FAIL directed_execute op=%h: we=%h done=%b, need we=%h done=0",
                         v[i].op, bus.we, bus.instruction_done, v[i].we);
            end
            step();
            checks++;
            if (bus.instruction_done !== 1'b1 || bus.we !== 7'h00) begin
                failures++;
                $display("FAIL directed_done op=%h: done=%b we=%h, need done=1 we=00",
                         v[i].op, bus.instruction_done, bus.we);
            end
            step();
            checks++;
            if (bus.instruction_done !== 1'b0 || bus.opp !== v[i].opp) begin
                failures++;
                $display("FAIL directed_idle op=%h: done=%b opp=%0d, need done=0 opp=%0d",
                         v[i].op, bus.instruction_done, bus.opp, v[i].opp);
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ops[2] = '{8'h89, 8'hFF};
        for (int i = 0; i < 2; i++) begin
            int we_seen   = 0;
            int done_seen = 0;
            accept_op(ops[i], 16'h4000);
            checks++;
            if (bus.illegal !== 1'b1 || bus.opp !== OPP_NOP || bus.addr_mode !== AM_IMPL ||
                bus.operand_bytes !== 2'd0) begin
                failures++;
                $display("FAIL illegal_decode op=%h: ill=%b opp=%0d mode=%0d bytes=%0d, need ill=1 opp=0 mode=0 bytes=0",
                         ops[i], bus.illegal, bus.opp, bus.addr_mode, bus.operand_bytes);
            end
            for (int c = 0; c < 4; c++) begin
                if (bus.we !== 7'h00) we_seen++;
                if (bus.instruction_done === 1'b1) done_seen++;
                step();
            end
            checks++;
            if (we_seen != 0 || done_seen != 1) begin
                failures++;
                $display("FAIL illegal_pulses op=%h: we_cycles=%0d done_pulses=%0d, need 0 and 1",
                         ops[i], we_seen, done_seen);
            end
        end
    endtask

    task automatic test_held_ready();
        int we_seen   = 0;
        int done_seen = 0;
        bus.instruction_in    = 8'hA5;
        bus.addr_in           = 16'h0200;
        bus.instruction_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.we !== 7'h00) we_seen++;
            if (bus.instruction_done === 1'b1) done_seen++;
        end
        bus.instruction_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.instruction_done === 1'b1) done_seen++;
        end
        checks++;
        if (we_seen != 1 || done_seen != 1) begin
            failures++;
            $display("FAIL held_ready: we_cycles=%0d done_pulses=%0d, need 1 and 1",
                     we_seen, done_seen);
        end
        checks++;
        if (bus.opp !== OPP_LDA || bus.addr_mode !== AM_ZP) begin
            failures++;
            $display("FAIL held_ready_fields: opp=%0d mode=%0d, need %0d %0d",
                     bus.opp, bus.addr_mode, OPP_LDA, AM_ZP);
        end
    endtask

    task automatic test_edge_while_busy();
        int done_seen = 0;
        accept_op(8'hA9, 16'h0300);
        // New edge in DECODE with a different opcode must be ignored.
        bus.instruction_in    = 8'h85;
        bus.addr_in           = 16'h0999;
        bus.instruction_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.instruction_done === 1'b1) done_seen++;
            step();
        end
        bus.instruction_ready = 1'b0;
        step();
        checks++;
        if (done_seen != 1 || bus.opp !== OPP_LDA || bus.inst_addr !== 16'h0300) begin
            failures++;
            $display("FAIL busy_edge: done_pulses=%0d opp=%0d addr=%h, need 1 %0d 0300",
                     done_seen, bus.opp, bus.inst_addr, OPP_LDA);
        end
    endtask

    task automatic test_reset_mid_execute();
        int done_seen = 0;
        accept_op(8'h6D, 16'h0400);
        step();
        checks++;
        if (bus.we !== 7'h24) begin
            failures++;
            $display("FAIL rst_mid_pre_we: we=%h, need 24", bus.we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.opp, bus.addr_mode, bus.operand_bytes, bus.inst_addr, bus.illegal,
             bus.we, bus.instruction_done} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: opp=%0d mode=%0d bytes=%0d addr=%h ill=%b we=%h done=%b, all must be 0",
                     bus.opp, bus.addr_mode, bus.operand_bytes, bus.inst_addr, bus.illegal,
                     bus.we, bus.instruction_done);
        end
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.instruction_done === 1'b1 || bus.we !== 7'h00) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL rst_mid_no_done: activity_cycles=%0d, need 0", done_seen);
        end
        accept_op(8'hA9, 16'h0500);
        checks++;
        if (bus.opp !== OPP_LDA || bus.inst_addr !== 16'h0500) begin
            failures++;
            $display("FAIL rst_mid_recover: opp=%0d addr=%h, need %0d 0500",
                     bus.opp, bus.inst_addr, OPP_LDA);
        end
        step(); step(); step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            logic [7:0]  op   = 8'($urandom_range(0, 255));
            logic [15:0] addr = 16'($urandom);
            accept_op(op, addr);
            checks++;
            if (bus.opp !== exp_opp[op] || bus.addr_mode !== exp_mode[op] ||
                bus.operand_bytes !== exp_bytes[op] || bus.illegal !== exp_ill[op] ||
                bus.inst_addr !== addr || bus.we !== 7'h00) begin
                failures++;
                $display("FAIL random_decode op=%h: opp=%0d mode=%0d bytes=%0d ill=%b addr=%h we=%h, need opp=%0d mode=%0d bytes=%0d ill=%b addr=%h we=00",
                         op, bus.opp, bus.addr_mode, bus.operand_bytes, bus.illegal,
                         bus.inst_addr, bus.we, exp_opp[op], exp_mode[op], exp_bytes[op],
                         exp_ill[op], addr);
            end
            step();
            checks++;
            if (bus.we !== exp_we[op] || bus.instruction_done !== 1'b0) begin
                failures++;
                $display("FAIL random_execute op=%h: we=%h done=%b, need we=%h done=0",
                         op, bus.we, bus.instruction_done, exp_we[op]);
            end
            step();
            checks++;
            if (bus.instruction_done !== 1'b1 || bus.we !== 7'h00) begin
                failures++;
                $display("FAIL random_done op=%h: done=%b we=%h, need done=1 we=00",
                         op, bus.instruction_done, bus.we);
            end
            step();
        end
    endtask

    initial begin
        build_model();
        test_reset();
        test_directed();
        test_illegal();
        test_held_ready();
        test_edge_while_busy();
        test_reset_mid_execute();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
